mem_bus_arbiter: RTL and testbench

Registered arbiter that shares the single byte-wide memory bus (instruction ROM, data RAM, memory-mapped IO) between the instruction-fetch shim and the data-memory shim of the multicycle Y86 core. Replaces the ad-hoc OR/last-writer-wins address muxing with an explicit ownership grant, per-byte strobe/ack handshake and fixed read-latency handling. It sits between the two shims and the RAM/IO address-decode logic.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_pick2.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the Y86 memory-bus arbiter.
//   - state_t : arbiter FSM states
//   - owner_t : current/last bus owner
//   - RD_LAT_MIN/RD_LAT_MAX and rd_lat_legal(): legal read-latency range
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,     // no owner, arbitration pass
    OWN,      // owner holds bus, no transfer in flight
    RD_WAIT,  // read issued, waiting out RAM latency
    WR        // write strobe on the bus this cycle
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic bit rd_lat_legal(int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin picker.
//   Ports:
//     req[1:0]   in  request vector, bit 0 = I-shim, bit 1 = D-shim
//     last_owner in  port that owned the bus most recently
//     pick       out port to grant (OWN_NONE when nobody requests)
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output owner_t     pick
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // output unassigned; otherwise synthesis infers a latch.
    pick = OWN_NONE;
    case (req)
      2'b01:   pick = OWN_I;
      2'b10:   pick = OWN_D;
      // Tie goes to whichever port did not own the bus last.
      2'b11:   pick = (last_owner == OWN_I) ? OWN_D : OWN_I;
      default: pick = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Registered arbiter sharing the byte-wide memory bus between the
//   instruction-fetch shim (read only) and the data-memory shim.
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     i_use/i_rd/i_addr               I-shim ownership request, read strobe, address
//     i_grant/i_ack/i_rdata           I-shim ownership, completion pulse, read data
//     d_use/d_rd/d_wr/d_addr/d_wdata  D-shim ownership request, strobes, address, data
//     d_grant/d_ack/d_rdata           D-shim ownership, completion pulse, read data
//     ram_use/ram_addr/ram_wdata      bus active, registered address and write byte
//     ram_rd/ram_wr                   one-cycle bus strobes
//     ram_rdata                       shared read-data bus, sampled RD_LAT cycles after ram_rd
//     proto_err                       sticky protocol-violation flag
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_use,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_use,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_use,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);

  if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_check
    $error("mem_bus_arbiter: RD_LAT out of range 1..3");
  end

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  owner_t            pick;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;   // owner let go of the bus mid-read
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, i_rdata_d, d_rdata_d;
  logic              rd_d, wr_d, i_ack_d, d_ack_d, err_d;
  logic              own_use, own_strobe;

  rr_pick2 u_pick (
    .req        ({d_use, i_use}),
    .last_owner (last_q),
    .pick       (pick)
  );

  // Grants and bus-active are decoded straight from the owner register.
  assign i_grant = (owner_q == OWN_I);
  assign d_grant = (owner_q == OWN_D);
  assign ram_use = (owner_q != OWN_NONE);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    addr_d    = ram_addr;
    wdata_d   = ram_wdata;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    err_d     = proto_err;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;

    own_use    = 1'b0;
    own_strobe = 1'b0;
    case (owner_q)
      OWN_I: begin
        own_use    = i_use;
        own_strobe = i_rd;
      end
      OWN_D: begin
        own_use    = d_use;
        own_strobe = d_rd | d_wr;
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (pick != OWN_NONE) begin
          owner_d = pick;
          state_d = OWN;
        end
      end

      OWN: begin
        if (!own_use) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
          last_d  = owner_q;
        end else if (owner_q == OWN_I && i_rd) begin
          addr_d  = i_addr;
          rd_d    = 1'b1;
          cnt_d   = LAT_LOAD;
          drop_d  = 1'b0;
          state_d = RD_WAIT;
        end else if (owner_q == OWN_D && d_wr) begin
          // Simultaneous read+write is resolved as a write and flagged.
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wr_d    = 1'b1;
          d_ack_d = 1'b1;
          err_d   = proto_err | d_rd;
          state_d = WR;
        end else if (owner_q == OWN_D && d_rd) begin
          addr_d  = d_addr;
          rd_d    = 1'b1;
          cnt_d   = LAT_LOAD;
          drop_d  = 1'b0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (own_strobe) err_d = 1'b1;
        if (!own_use)   drop_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (drop_q || !own_use) begin
          // RAM side has finished; the abandoned result is discarded.
          state_d = IDLE;
          owner_d = OWN_NONE;
          last_d  = owner_q;
        end else begin
          state_d = OWN;
          if (owner_q == OWN_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = ram_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = ram_rdata;
          end
        end
      end

      WR: begin
        if (own_strobe) err_d = 1'b1;
        state_d = OWN;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      last_q    <= OWN_D;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      ram_rd    <= rd_d;
      ram_wr    <= wr_d;
      i_ack     <= i_ack_d;
      d_ack     <= d_ack_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
      proto_err <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter (RD_LAT = 3). A transaction-level
//   model tracks owner, last owner, bus address/data, read data and the error
//   flag; every cycle all DUT outputs are compared against it.
module tb_mem_bus_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_use = 1'b0, i_rd = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_grant, i_ack;
  logic [7:0]  i_rdata;
  logic        d_use = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [31:0] d_addr = '0;
  logic [7:0]  d_wdata = '0;
  logic        d_grant, d_ack;
  logic [7:0]  d_rdata;
  logic        ram_use, ram_rd, ram_wr, proto_err;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  int checks = 0;
  int failures = 0;

  // Model: owner/last 0 = none, 1 = I, 2 = D
  int          m_owner = 0;
  int          m_last = 2;
  logic [31:0] m_addr = '0;
  logic [7:0]  m_wdata = '0, m_irdata = '0, m_drdata = '0;
  logic        m_err = 1'b0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(8), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_use(i_use), .i_rd(i_rd), .i_addr(i_addr),
    .i_grant(i_grant), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_use(d_use), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_use(ram_use), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_rdata(ram_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag, bit e_rd, bit e_wr, bit e_iack, bit e_dack);
    check({tag, ".i_grant"},   32'(i_grant),   32'(m_owner == 1));
    check({tag, ".d_grant"},   32'(d_grant),   32'(m_owner == 2));
    check({tag, ".ram_use"},   32'(ram_use),   32'(m_owner != 0));
    check({tag, ".ram_addr"},  ram_addr,       m_addr);
    check({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(m_wdata));
    check({tag, ".ram_rd"},    32'(ram_rd),    32'(e_rd));
    check({tag, ".ram_wr"},    32'(ram_wr),    32'(e_wr));
    check({tag, ".i_ack"},     32'(i_ack),     32'(e_iack));
    check({tag, ".d_ack"},     32'(d_ack),     32'(e_dack));
    check({tag, ".i_rdata"},   32'(i_rdata),   32'(m_irdata));
    check({tag, ".d_rdata"},   32'(d_rdata),   32'(m_drdata));
    check({tag, ".proto_err"}, 32'(proto_err), 32'(m_err));
  endtask

  // Advance one cycle; strobes are one-cycle, so they drop after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    i_rd = 1'b0;
    d_rd = 1'b0;
    d_wr = 1'b0;
  endtask

  function automatic int arb_pick(bit ri, bit rd);
    if (ri && rd) return (m_last == 1) ? 2 : 1;
    if (ri) return 1;
    if (rd) return 2;
    return 0;
  endfunction

  task automatic set_use(int port, bit v);
    if (port == 1) i_use = v;
    else d_use = v;
  endtask

  // Random strobes from the non-owning port; these must never reach the bus.
  task automatic noise(int owner);
    if (owner == 1) begin
      d_rd    = 1'($urandom_range(0, 1));
      d_wr    = 1'($urandom_range(0, 1));
      d_addr  = $urandom;
      d_wdata = 8'($urandom);
    end else if (owner == 2) begin
      i_rd   = 1'($urandom_range(0, 1));
      i_addr = $urandom;
    end
  endtask

  task automatic do_reset();
    i_use = 1'b0; d_use = 1'b0;
    reset = 1'b1;
    tick();
    m_owner = 0; m_last = 2; m_addr = '0; m_wdata = '0;
    m_irdata = '0; m_drdata = '0; m_err = 1'b0;
    check_all("reset", 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // Called only while the model says the bus is idle.
  task automatic request(bit ri, bit rd);
    i_use = ri; d_use = rd;
    tick();
    m_owner = arb_pick(ri, rd);
    check_all("grant", 0, 0, 0, 0);
  endtask

  task automatic release_bus(int port);
    int other;
    other = (port == 1) ? 2 : 1;
    set_use(port, 1'b0);
    noise(port);
    tick();
    m_owner = 0; m_last = port;
    check_all("release", 0, 0, 0, 0);
    if ((other == 1 && i_use) || (other == 2 && d_use)) begin
      tick();
      m_owner = other;
      check_all("regrant", 0, 0, 0, 0);
    end
  endtask

  // ram_rdata carries the real byte only in the cycle it must be sampled.
  task automatic do_read(int port, logic [31:0] a, logic [7:0] v, int bad_k, int drop_k);
    if (port == 1) begin i_rd = 1'b1; i_addr = a; end
    else begin d_rd = 1'b1; d_addr = a; end
    noise(port);
    ram_rdata = ~v;
    tick();
    m_addr = a;
    check_all("rd_issue", 1, 0, 0, 0);
    for (int k = 1; k <= LAT; k++) begin
      if (k == bad_k) begin
        if (port == 1) i_rd = 1'b1;
        else d_wr = 1'b1;
      end
      if (k == drop_k) set_use(port, 1'b0);
      noise(port);
      tick();
      if (k == bad_k) m_err = 1'b1;
      check_all("rd_wait", 0, 0, 0, 0);
    end
    ram_rdata = v;
    noise(port);
    tick();
    ram_rdata = ~v;
    if (drop_k != 0) begin
      m_owner = 0; m_last = port;
      check_all("rd_drop", 0, 0, 0, 0);
    end else begin
      if (port == 1) m_irdata = v;
      else m_drdata = v;
      check_all("rd_ack", 0, 0, port == 1, port == 2);
    end
  endtask

  task automatic do_write(logic [31:0] a, logic [7:0] v, bit both, bit bad);
    d_wr = 1'b1; d_rd = both; d_addr = a; d_wdata = v;
    noise(2);
    tick();
    m_addr = a; m_wdata = v;
    if (both) m_err = 1'b1;
    check_all("wr", 0, 1, 0, 1);
    if (bad) d_rd = 1'b1;
    noise(2);
    tick();
    if (bad) m_err = 1'b1;
    check_all("wr_gap", 0, 0, 0, 0);
  endtask

  task automatic random_op(int port);
    repeat ($urandom_range(0, 2)) begin
      noise(port);
      tick();
      check_all("gap", 0, 0, 0, 0);
    end
    if (port == 2 && $urandom_range(0, 1) == 1)
      do_write($urandom, 8'($urandom), 1'b0, 1'b0);
    else
      do_read(port, $urandom, 8'($urandom), 0, 0);
  endtask

  initial begin
    int r, w, o;

    // I-shim read, then D-shim write
    do_reset();
    request(1'b1, 1'b0);
    do_read(1, 32'h0000_0010, 8'h30, 0, 0);
    release_bus(1);
    request(1'b0, 1'b1);
    do_write(32'h0000_F004, 8'h5A, 1'b0, 1'b0);
    release_bus(2);

    // Round-robin ties
    do_reset();
    request(1'b1, 1'b1);       // I wins first tie
    release_bus(1);            // D granted two cycles after release
    release_bus(2);
    request(1'b1, 1'b1);       // last was D -> I
    d_use = 1'b0;
    release_bus(1);
    request(1'b1, 1'b1);       // last was I -> D
    release_bus(2);            // I waiting -> regranted
    release_bus(1);

    // Protocol errors: rd+wr together, strobe in RD_WAIT, strobe in WR
    do_reset();
    request(1'b0, 1'b1);
    do_write(32'h0000_00A0, 8'h11, 1'b1, 1'b0);
    do_read(2, 32'h0000_00B0, 8'h22, 2, 0);
    do_write(32'h0000_00C0, 8'h33, 1'b0, 1'b1);
    release_bus(2);
    repeat (2) begin
      tick();
      check_all("err_sticky", 0, 0, 0, 0);
    end

    // Owner drops mid-read; waiting D granted after the IDLE pass
    do_reset();
    request(1'b1, 1'b0);
    d_use = 1'b1;
    do_read(1, 32'h0000_0020, 8'h77, 0, 2);
    request(1'b0, 1'b1);
    release_bus(2);

    // Randomized ownership/transfer sequences
    do_reset();
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(1, 3);
      request(r[0], r[1]);
      w = m_owner;
      repeat ($urandom_range(1, 3)) random_op(w);
      release_bus(w);
      if (m_owner != 0) begin
        o = m_owner;
        repeat ($urandom_range(1, 2)) random_op(o);
        release_bus(o);
      end
    end

    // Reset while a read is in flight
    do_reset();
    request(1'b1, 1'b0);
    do_write_guard: begin
      i_rd = 1'b1; i_addr = 32'h0000_0044;
      tick();
      m_addr = 32'h0000_0044;
      check_all("mid_issue", 1, 0, 0, 0);
      ram_rdata = 8'hC3;
      tick();
      check_all("mid_wait", 0, 0, 0, 0);
    end
    do_reset();
    repeat (LAT + 3) begin
      tick();
      check_all("post_rst", 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
